// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game datapath.
// Holds the video timing limits and the vblank scheduler state encoding.
package pong_pkg;

  localparam logic [9:0] H_MAX    = 10'h320;
  localparam logic [9:0] V_MAX    = 10'h20D;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] H_ACTIVE = 10'd640;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set candidate at or
// after i_ptr, wrapping around, as a one-hot vector plus a valid flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_cand,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic          o_valid
);

  // Walk the indices in rotated order; the first hit wins.
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    o_onehot = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(i_ptr) + i) % N);
      if (!found && i_cand[idx]) begin
        o_onehot[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    o_valid = found;
  end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants game-logic requesters exclusive access during vertical blanking,
// once per frame each, with round-robin priority rotating every frame.
module vblank_update_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int V_ACTIVE = int'(pong_pkg::V_ACTIVE),
  parameter int V_MAX    = int'(pong_pkg::V_MAX),
  parameter int TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         counter_x,
  input  logic [9:0]         counter_y,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               update_window,
  output logic               frame_tick,
  output logic               busy,
  output logic [NUM_REQ-1:0] timeout_err,
  output logic               overrun
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);

  pong_pkg::sched_state_t r_state;

  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_req;
  logic [NUM_REQ-1:0] r_served;
  logic [NUM_REQ-1:0] r_timeout_err;
  logic               r_window;
  logic               r_frame_tick;
  logic               r_busy;
  logic               r_overrun;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [HOLD_W-1:0]  r_hold;

  logic               w_open;
  logic               w_close;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_pick_valid;
  logic               w_done_hit;
  logic               w_timeout;
  logic               w_release;

  assign w_open     = (counter_y == 10'(V_ACTIVE)) && (counter_x == 10'd0);
  assign w_close    = (counter_y == 10'(V_MAX)) && (counter_x == 10'd0);
  assign w_cand     = r_req & ~r_served;
  assign w_done_hit = |(done & r_grant);
  assign w_timeout  = (r_hold == HOLD_LAST) && !w_done_hit;
  assign w_release  = (r_state == pong_pkg::GRANT) && (w_done_hit || w_timeout);

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .i_cand   (w_cand),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick),
    .o_valid  (w_pick_valid)
  );

  // Requests pass through a register so arbitration sees a stable mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= pong_pkg::IDLE;
      r_grant       <= '0;
      r_req         <= '0;
      r_served      <= '0;
      r_timeout_err <= '0;
      r_window      <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_rr_ptr      <= '0;
      r_hold        <= '0;
    end else begin
      r_req        <= req;
      r_frame_tick <= w_open && !r_window;

      if (w_open) begin
        r_window <= 1'b1;
      end else if (w_close) begin
        r_window <= 1'b0;
      end

      if (w_close && r_window && (r_state == pong_pkg::GRANT)) begin
        r_overrun <= 1'b1;
      end

      if (r_frame_tick) begin
        r_rr_ptr <= (r_rr_ptr == PTR_LAST) ? '0 : r_rr_ptr + 1'b1;
      end

      // A new frame wipes the served history even if a grant is still running.
      if (r_frame_tick) begin
        r_served <= '0;
      end else if (w_release) begin
        r_served <= r_served | r_grant;
      end

      if (w_release && w_timeout) begin
        r_timeout_err <= r_timeout_err | r_grant;
      end

      case (r_state)
        pong_pkg::IDLE: begin
          if (r_frame_tick) begin
            r_state <= pong_pkg::ARB;
          end
        end
        pong_pkg::ARB: begin
          if (!r_window) begin
            r_state <= pong_pkg::IDLE;
          end else if (w_pick_valid) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_hold  <= '0;
            r_state <= pong_pkg::GRANT;
          end
        end
        pong_pkg::GRANT: begin
          if (w_release) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= r_window ? pong_pkg::ARB : pong_pkg::IDLE;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= pong_pkg::IDLE;
        end
      endcase
    end
  end

  assign grant         = r_grant;
  assign update_window = r_window;
  assign frame_tick    = r_frame_tick;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Self-checking bench for vblank_update_scheduler: table of frames, directed
// corner cases, and random frames checked against a round-robin frame model.
module tb_vblank_update_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 1024;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [9:0]      counter_x;
  logic [9:0]      counter_y;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] grant;
  logic            update_window;
  logic            frame_tick;
  logic            busy;
  logic [NREQ-1:0] timeout_err;
  logic            overrun;

  int checks = 0;
  int fails  = 0;
  int modelPtr = 0;

  typedef struct {
    logic [3:0]  reqMask;
    logic [15:0] expSeq;
    int          expCount;
  } frame_vec_t;

  frame_vec_t vecs[8];

  vblank_update_scheduler #(
    .NUM_REQ  (NREQ),
    .V_ACTIVE (480),
    .V_MAX    (525),
    .TIMEOUT  (TMO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .counter_x     (counter_x),
    .counter_y     (counter_y),
    .req           (req),
    .done          (done),
    .grant         (grant),
    .update_window (update_window),
    .frame_tick    (frame_tick),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d,
                               input logic [9:0] x, input logic [9:0] y);
    req       = r;
    done      = d;
    counter_x = x;
    counter_y = y;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Grant"}, grant, 0);
    checkOutput({tag, "Window"}, update_window, 0);
    checkOutput({tag, "Tick"}, frame_tick, 0);
    checkOutput({tag, "Busy"}, busy, 0);
    checkOutput({tag, "TimeoutErr"}, timeout_err, 0);
    checkOutput({tag, "Overrun"}, overrun, 0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 10'd1, 10'd0);
    repeat (3) step();
    checkAllZero("reset");
    reset_n = 1'b1;
    step();
    modelPtr = 0;
  endtask

  task automatic openWindow();
    counter_y = 10'd480;
    counter_x = 10'd0;
    step();
    checkOutput("frameTickRise", frame_tick, 1);
    checkOutput("windowOpen", update_window, 1);
    counter_x = 10'd1;
    step();
    checkOutput("frameTickPulse", frame_tick, 0);
    modelPtr = (modelPtr + 1) % NREQ;
  endtask

  task automatic closeWindow();
    counter_y = 10'd525;
    counter_x = 10'd0;
    step();
    checkOutput("windowClose", update_window, 0);
    counter_y = 10'd0;
    counter_x = 10'd1;
  endtask

  task automatic waitGrant(input int bound, output int waited);
    waited = 0;
    while (grant == 0 && waited < bound) begin
      step();
      waited++;
    end
    if (grant == 0) checkOutput("grantWaitBound", 0, 1);
  endtask

  // Grant is visible in the current sample; hold it delay cycles, then strobe done.
  task automatic holdAndDone(input logic [3:0] g, input int delay, input bit noise);
    int bad = 0;
    for (int i = 1; i < delay; i++) begin
      done = noise ? (4'($urandom) & ~g) : 4'b0000;
      step();
      if (grant !== g) bad++;
    end
    done = g | (noise ? (4'($urandom) & ~g) : 4'b0000);
    step();
    done = 4'b0000;
    checkOutput("grantHeld", bad, 0);
    checkOutput("grantDrop", grant, 0);
    checkOutput("busyDrop", busy, 0);
  endtask

  task automatic serveFrame(input logic [3:0] reqMask, input logic [15:0] expSeq,
                            input int expCount, input int delay, input bit noise);
    int waited;
    int extra = 0;
    req = reqMask;
    openWindow();
    for (int k = 0; k < expCount; k++) begin
      if (k == 0) begin
        waitGrant(10, waited);
        checkOutput("firstGrantLatency", waited, 1);
      end else begin
        step();
      end
      checkOutput($sformatf("grantOrder%0d", k), grant, expSeq[4*k +: 4]);
      checkOutput("busyHigh", busy, 1);
      holdAndDone(expSeq[4*k +: 4], delay, noise);
    end
    repeat (15) begin
      step();
      if (grant != 0) extra++;
    end
    checkOutput("noExtraGrant", extra, 0);
    checkOutput("noOverrun", overrun, 0);
    closeWindow();
  endtask

  initial begin
    int waited;
    int cnt;
    int p;
    int idx;
    logic [3:0]  mask;
    logic [15:0] seq;

    vecs[0] = '{4'b1111, 16'h1842, 4};
    vecs[1] = '{4'b1111, 16'h2184, 4};
    vecs[2] = '{4'b1111, 16'h4218, 4};
    vecs[3] = '{4'b1111, 16'h8421, 4};
    vecs[4] = '{4'b1001, 16'h0018, 2};
    vecs[5] = '{4'b0011, 16'h0021, 2};
    vecs[6] = '{4'b0000, 16'h0000, 0};
    vecs[7] = '{4'b0110, 16'h0042, 2};

    // Reset asserted in the middle of a grant clears everything at once.
    doReset();
    req = 4'b1111;
    openWindow();
    waitGrant(10, waited);
    checkOutput("preResetGrant", grant, 4'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("asyncReset");
    step();
    step();
    reset_n = 1'b1;
    modelPtr = 0;
    cnt = 0;
    repeat (40) begin
      step();
      if (grant != 0 || update_window != 0) cnt++;
    end
    checkOutput("noGrantAfterReset", cnt, 0);
    serveFrame(4'b1111, 16'h1842, 4, 2, 1'b0);

    // Two requesters, first frame after reset.
    doReset();
    serveFrame(4'b0101, 16'h0014, 2, 3, 1'b0);

    // Frame table with rotating start priority.
    doReset();
    for (int i = 0; i < 8; i++) begin
      serveFrame(vecs[i].reqMask, vecs[i].expSeq, vecs[i].expCount, 3, 1'b0);
    end

    // Requester never finishes: forced release after TMO cycles.
    doReset();
    req = 4'b0110;
    openWindow();
    waitGrant(10, waited);
    checkOutput("timeoutFirstGrant", grant, 4'b0010);
    cnt = 0;
    while (grant == 4'b0010 && cnt < TMO + 100) begin
      cnt++;
      step();
    end
    checkOutput("timeoutHoldCycles", cnt, TMO);
    checkOutput("timeoutErrFlag", timeout_err, 4'b0010);
    checkOutput("timeoutGap", grant, 0);
    step();
    checkOutput("afterTimeoutGrant", grant, 4'b0100);
    holdAndDone(4'b0100, 3, 1'b0);
    closeWindow();
    serveFrame(4'b0011, 16'h0021, 2, 2, 1'b0);
    checkOutput("timeoutErrSticky", timeout_err, 4'b0010);

    // Grant still running when the window closes.
    doReset();
    req = 4'b0010;
    openWindow();
    waitGrant(10, waited);
    checkOutput("overrunGrant", grant, 4'b0010);
    counter_y = 10'd524;
    counter_x = 10'd10;
    repeat (3) step();
    counter_y = 10'd525;
    counter_x = 10'd0;
    step();
    checkOutput("overrunWindow", update_window, 0);
    checkOutput("overrunFlag", overrun, 1);
    checkOutput("overrunBusy", busy, 1);
    counter_y = 10'd0;
    counter_x = 10'd1;
    req = 4'b1111;
    repeat (5) step();
    checkOutput("overrunGrantKept", grant, 4'b0010);
    done = 4'b0010;
    step();
    done = 4'b0000;
    checkOutput("overrunRelease", grant, 0);
    cnt = 0;
    repeat (30) begin
      step();
      if (grant != 0) cnt++;
    end
    checkOutput("overrunNoRegrant", cnt, 0);
    checkOutput("overrunSticky", overrun, 1);
    openWindow();
    waitGrant(10, waited);
    checkOutput("overrunNextFrame", grant, 4'b0100);

    // done from a non-granted requester must be ignored.
    doReset();
    serveFrame(4'b0000, 16'h0000, 0, 1, 1'b0);
    serveFrame(4'b0000, 16'h0000, 0, 1, 1'b0);
    req = 4'b0011;
    openWindow();
    waitGrant(10, waited);
    checkOutput("foreignFirst", grant, 4'b0001);
    done = 4'b1110;
    step();
    done = 4'b0000;
    checkOutput("foreignDoneIgnored", grant, 4'b0001);
    step();
    checkOutput("foreignDoneStill", grant, 4'b0001);
    done = 4'b0001;
    step();
    done = 4'b0000;
    checkOutput("foreignRelease", grant, 0);
    step();
    checkOutput("foreignServedClean", grant, 4'b0010);
    holdAndDone(4'b0010, 2, 1'b0);
    closeWindow();

    // Random frames against a rotate-and-scan frame model.
    doReset();
    for (int f = 0; f < 12; f++) begin
      mask = 4'($urandom_range(0, 15));
      p    = (modelPtr + 1) % NREQ;
      seq  = '0;
      cnt  = 0;
      for (int i = 0; i < NREQ; i++) begin
        idx = (p + i) % NREQ;
        if (mask[idx]) begin
          seq[4*cnt +: 4] = 4'(1 << idx);
          cnt++;
        end
      end
      serveFrame(mask, seq, cnt, int'($urandom_range(1, 8)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
